// File: rtl/nonrestoringdiv_param.sv
// nonrestoringdiv_param: sequential non-restoring divider, one quotient bit per cycle.
// Define NRDIV_SIGNED_EN for two's-complement operands (truncating division).
module nonrestoringdiv_param #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Q_out,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             busy,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   nxt;
    logic [WIDTH-1:0] fixed;
    logic [WIDTH-1:0] qin;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
`ifdef NRDIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    always_comb begin
        qin = Q[WIDTH-1] ? -Q : Q;
        min = M[WIDTH-1] ? -M : M;
        quo = neg_q ? -qr : qr;
        rem = neg_r ? -fixed : fixed;
        dvd = neg_r ? -qr : qr;
    end
`else
    always_comb begin
        qin = Q;
        min = M;
        quo = qr;
        rem = fixed;
        dvd = qr;
    end
`endif
    // accumulator and quotient shift together; the sign picks add or subtract
    always_comb begin
        sh    = {acc[WIDTH-1:0], qr[WIDTH-1]};
        nxt   = acc[WIDTH] ? sh + {1'b0, m} : sh - {1'b0, m};
        fixed = acc[WIDTH] ? acc[WIDTH-1:0] + m : acc[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            qr    <= '0;
            m     <= '0;
            cnt   <= '0;
            Q_out <= '0;
            R     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            dz    <= 1'b0;
`ifdef NRDIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    qr    <= qin;
                    m     <= min;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH);
                    busy  <= 1'b1;
                    dz    <= 1'b0;
                    state <= ITER;
`ifdef NRDIV_SIGNED_EN
                    neg_q <= Q[WIDTH-1] ^ M[WIDTH-1];
                    neg_r <= Q[WIDTH-1];
`endif
                end
                ITER: if (m == '0) begin
                    Q_out <= '1;
                    R     <= dvd;
                    dz    <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    acc <= nxt;
                    qr  <= {qr[WIDTH-2:0], ~nxt[WIDTH]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    Q_out <= quo;
                    R     <= rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonrestoringdiv_param.sv
// tb_nonrestoringdiv_param: scoreboard bench for 8-bit and 512-bit divider instances.
module tb_nonrestoringdiv_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic         start8 = 1'b0;
    logic [7:0]   q8 = '0, m8 = '0, qo8, r8;
    logic         done8, busy8, dz8;
    logic         start_l = 1'b0;
    logic [511:0] ql = '0, ml = '0, qol, rl;
    logic         donel, busyl, dzl;
    int total = 0;
    int bad = 0;
    typedef struct packed {logic [7:0] q, r; logic dz;} exp8_t;
    typedef struct packed {logic [511:0] a, b;} op_t;
    exp8_t sb8[$];
    op_t   sbl[$];
    exp8_t e8;
    op_t   ol;

    nonrestoringdiv_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .Q(q8), .M(m8),
        .Q_out(qo8), .R(r8), .done(done8), .busy(busy8), .dz(dz8)
    );
    nonrestoringdiv_param #(.WIDTH(512)) ul (
        .clk(clk), .rst(rst), .start(start_l), .Q(ql), .M(ml),
        .Q_out(qol), .R(rl), .done(donel), .busy(busyl), .dz(dzl)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
        exp8_t e;
`ifdef NRDIV_SIGNED_EN
        int sa, sb;
`endif
        if (b == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
`ifdef NRDIV_SIGNED_EN
            sa   = $signed(a);
            sb   = $signed(b);
            e.q  = 8'(sa / sb);
            e.r  = 8'(sa % sb);
`else
            e.q  = a / b;
            e.r  = a % b;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) if (done8) begin
        if (sb8.size() == 0) check("done8_spurious", 1, 0);
        else begin
            e8 = sb8.pop_front();
            check("q8", qo8, e8.q);
            check("r8", r8, e8.r);
            check("dz8", dz8, e8.dz);
        end
    end

    always @(negedge clk) if (donel) begin
        if (sbl.size() == 0) check("donel_spurious", 1, 0);
        else begin
            ol = sbl.pop_front();
            check("ql", qol, ol.a / ol.b);
            check("rl", rl, ol.a % ol.b);
            check("recon", qol * ol.b + rl, ol.a);
            check("r_lt_m", rl < ol.b, 1);
            check("dzl", dzl, 0);
        end
    end

    task automatic wait8(output int n);
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int n;
        exp8_t e;
        e = model8(a, b);
        @(negedge clk);
        q8 = a; m8 = b; start8 = 1'b1;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; q8 = ~a; m8 = 8'($urandom);
        check("busy8", busy8, 1);
        wait8(n);
        check("lat8", n, (b == 8'd0) ? 1 : 9);
        check("busy8_end", busy8, 0);
        @(negedge clk);
        check("done8_pulse", done8, 0);
        check("hold8", qo8, e.q);
    endtask

    task automatic runl(input logic [511:0] a, input logic [511:0] b);
        int n;
        @(negedge clk);
        ql = a; ml = b; start_l = 1'b1;
        sbl.push_back({a, b});
        @(negedge clk);
        start_l = 1'b0; ql = '0; ml = '0;
        n = 0;
        while (!donel && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("latl", n, 513);
    endtask

    initial begin
        int n, k;
        logic [511:0] a, b;
        repeat (3) @(negedge clk);
        check("rst_q", qo8, 0);
        check("rst_r", r8, 0);
        check("rst_done", done8, 0);
        check("rst_busy", busy8, 0);
        check("rst_dz", dz8, 0);
        rst = 1'b0;
        run8(8'd100, 8'd7);
        // back-to-back with start held; operand changes while busy must not matter
        @(negedge clk);
        q8 = 8'd5; m8 = 8'd9; start8 = 1'b1;
        sb8.push_back(model8(8'd5, 8'd9));
        @(negedge clk);
        q8 = 8'd255; m8 = 8'd1;
        sb8.push_back(model8(8'd255, 8'd1));
        wait8(n);
        check("lat_b2b1", n, 9);
        @(negedge clk);
        start8 = 1'b0;
        check("busy_b2b", busy8, 1);
        wait8(k);
        check("gap_b2b", k + 1, 10);
        run8(8'd77, 8'd0);
        run8(8'd10, 8'd3);
        @(negedge clk);
        q8 = 8'd200; m8 = 8'd3; start8 = 1'b1;
        sb8.push_back(model8(8'd200, 8'd3));
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_q", qo8, 0);
        check("abort_r", r8, 0);
        check("abort_dz", dz8, 0);
        sb8.delete();
        repeat (15) @(negedge clk);
        run8(8'd200, 8'd3);
        run8(8'h9C, 8'd7);
        run8(8'h80, 8'hFF);
        run8(8'h9C, 8'd0);
        run8(8'd0, 8'd5);
        run8(8'd254, 8'd255);
        for (int i = 0; i < 8; i++) run8(8'($urandom), 8'($urandom_range(1, 255)));
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 16; i++) begin
                a[i*32 +: 32] = $urandom;
                b[i*32 +: 32] = $urandom;
            end
            a[511] = 1'b0;
            b[511] = 1'b0;
            b = (j == 0) ? (b >> 3) : (b >> 400);
            b[0] = 1'b1;
            runl(a, b);
        end
        repeat (3) @(negedge clk);
        check("sb8_empty", sb8.size(), 0);
        check("sbl_empty", sbl.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nonrestoringdiv_param.md
NONRESTORINGDIV_PARAM -- requirements
Module: nonrestoringdiv_param

Interface
REQ-001 SHALL have parameter: WIDTH, 512, operand/result width in bits (legal range 2..1024).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: Q  input  WIDTH  dividend; sampled on accepting edge only.
REQ-006 SHALL have port: M  input  WIDTH  divisor; sampled on accepting edge only.
REQ-007 SHALL have port: Q_out  output  WIDTH  quotient, registered.
REQ-008 SHALL have port: R  output  WIDTH  remainder, registered.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port: busy  output  1  high while a division is in flight.
REQ-011 SHALL have port: dz  output  1  divide-by-zero flag; valid with done, held until next accept.

Function
REQ-012 SHALL implement FSM states IDLE, ITER, FIX.
REQ-013 IDLE: start=1 at an edge SHALL latch Q, M, clear the WIDTH+1-bit accumulator, load iteration count WIDTH, set busy=1, and go to ITER. This edge is the accept edge, E0.
REQ-014 ITER: each edge SHALL produce one quotient bit, MSB first, using the non-restoring rule.
- Accumulator >= 0: shift left, then subtract M.
- Accumulator < 0: shift left, then add M.
- Quotient bit = NOT new accumulator sign.
REQ-015 After WIDTH ITER edges (E1..E_WIDTH) the FSM SHALL go to FIX.
REQ-016 FIX, at edge E_WIDTH+1: if the accumulator is negative, SHALL add M. Then SHALL register Q_out and R, pulse done=1 for exactly one cycle, set busy=0, and return to IDLE.
REQ-017 Latency SHALL be exactly WIDTH+1 cycles from E0 to the done-asserting edge, independent of data.
REQ-018 start while busy=1 SHALL be ignored; Q/M changes during busy SHALL NOT affect the result.
REQ-019 start held high SHALL be accepted on the edge after done, so back-to-back operation has a one-cycle IDLE gap.
REQ-020 M==0 at accept SHALL skip ITER and FIX. On E1: Q_out=all ones, R=dividend, dz=1, done=1, busy=0.
REQ-021 dz SHALL clear on the next accept edge.
REQ-022 Q_out, R and dz SHALL hold their last values between done and the next done.
REQ-023 Unsigned arithmetic SHALL give Q_out=floor(Q/M) and R=Q-Q_out*M, with 0<=R<M, for every nonzero M.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE from any state, including mid-ITER, and abandon the division.
REQ-025 rst SHALL clear Q_out=0, R=0, done=0, busy=0, dz=0, the count and the accumulator.
REQ-026 rst SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro NRDIV_SIGNED_EN defined: Q and M SHALL be two's complement.
- Magnitudes SHALL be taken at accept.
- Quotient SHALL be negated in FIX when the operand signs differ (truncation toward zero).
- R SHALL take the sign of the dividend.
- Latency SHALL be unchanged.
- Most-negative/-1 SHALL give Q_out=most-negative, R=0, dz=0.
- Divide-by-zero SHALL give Q_out=all ones, R=dividend.
REQ-028 Macro NRDIV_SIGNED_EN undefined: unsigned only; no sign logic SHALL be synthesised.

Verification (WIDTH=8 unless noted)
REQ-029 Q=100, M=7, start pulse -> done exactly 9 cycles after E0; Q_out=14, R=2, dz=0; busy high for E0..E8.
REQ-030 Q=5, M=9 -> Q_out=0, R=5; then Q=255, M=1 back-to-back with start held -> Q_out=255, R=0; second done 10 cycles after the first.
REQ-031 Q=77, M=0 -> done on E1; Q_out=0xFF, R=77, dz=1; next division 10/3 -> dz=0, Q_out=3, R=1.
REQ-032 rst asserted 4 cycles into 200/3 -> next edge busy=0, done=0, Q_out=0, R=0; no done pulse follows; a fresh 200/3 -> Q_out=66, R=2.
REQ-033 NRDIV_SIGNED_EN, Q=0x9C (-100), M=7 -> Q_out=0xF2 (-14), R=0xFE (-2); Q=0x80, M=0xFF -> Q_out=0x80, R=0.
REQ-034 WIDTH=512, the 512-bit dividend/divisor pair -> done after 513 cycles; Q_out*M+R equals the dividend with R<M (checked by bench model).
